// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int NUM_REQ = 2;

    // IDLE: open round-robin contest; LOCKn: requester n holds the RAM port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // Locked state belonging to a given requester index.
    function automatic arb_state_t lock_state(input logic sel);
        return sel ? LOCK1 : LOCK0;
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins; on a tie the requester
// that was not served last wins.
module rr_pick
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_last,
    output logic [NUM_REQ-1:0] o_gnt
);

    // Tie goes to the opposite of the last winner.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arb.sv
// Round-robin arbiter sharing one synchronous RAM port (1-cycle read latency)
// between the UART loader (req 0) and the CPU data path (req 1), with locked
// bursts capped at MAX_BURST beats.
//
// state | meaning
// IDLE  | no owner; grant by round-robin pick
// LOCK0 | requester 0 holds the port for a locked burst
// LOCK1 | requester 1 holds the port for a locked burst
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [NUM_REQ-1:0]             we_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   addr_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   wr_data_i,
    input  logic [NUM_REQ-1:0][3:0]        byte_en_i,
    input  logic [NUM_REQ-1:0]             lock_i,
    output logic [NUM_REQ-1:0]             gnt_o,
    output logic [XLEN-1:0]                rd_data_o,
    output logic [NUM_REQ-1:0]             rd_vld_o,
    output logic                           mem_en_o,
    output logic                           mem_we_o,
    output logic [XLEN-1:0]                mem_addr_o,
    output logic [XLEN-1:0]                mem_wr_data_o,
    output logic [3:0]                     mem_byte_en_o,
    input  logic [XLEN-1:0]                mem_rd_data_i,
    output logic                           owner_o,
    output logic                           busy_o
);

    localparam int            CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_BURST);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                r_last;
    logic                r_owner;
    logic [CW-1:0]       r_beat_cnt;
    logic [CW-1:0]       w_beat_nxt;
    logic [CW-1:0]       w_beat_inc;
    logic [NUM_REQ-1:0]  r_rd_vld;
    logic [NUM_REQ-1:0]  w_pick;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [NUM_REQ-1:0]  w_xfer;
    logic                w_xfer_any;
    logic                w_sel;

    rr_pick u_rr_pick (
        .i_req  (req_i),
        .i_last (r_last),
        .o_gnt  (w_pick)
    );

    // Grant: round-robin in IDLE, owner-only while locked, nothing in reset.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst_i) begin
            case (r_state)
                IDLE:    w_gnt = w_pick;
                LOCK0:   w_gnt = {1'b0, req_i[0]};
                LOCK1:   w_gnt = {req_i[1], 1'b0};
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign w_xfer     = req_i & w_gnt;
    assign w_xfer_any = |w_xfer;
    assign w_sel      = w_gnt[1];
    assign w_beat_inc = r_beat_cnt + CW'(1);

    // Next state and beat count; a beat that reaches the cap always releases.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        if (r_state != IDLE && !req_i[r_state == LOCK1]) begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
        end else if (w_xfer_any) begin
            if (lock_i[w_sel] && (w_beat_inc < C_MAX)) begin
                w_state_nxt = lock_state(w_sel);
                w_beat_nxt  = w_beat_inc;
            end else begin
                w_state_nxt = IDLE;
                w_beat_nxt  = '0;
            end
        end
    end

    // State, round-robin pointer, owner and read-return pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_beat_cnt <= '0;
            r_rd_vld   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_rd_vld   <= w_xfer & ~we_i;
            if (w_xfer_any) begin
                r_last  <= w_sel;
                r_owner <= w_sel;
            end
        end
    end

    assign gnt_o         = w_gnt;
    assign mem_en_o      = w_xfer_any;
    assign mem_we_o      = w_xfer_any & we_i[w_sel];
    assign mem_addr_o    = addr_i[w_sel];
    assign mem_wr_data_o = wr_data_i[w_sel];
    assign mem_byte_en_o = (w_xfer_any && we_i[w_sel]) ? byte_en_i[w_sel] : 4'b0000;
    assign rd_data_o     = mem_rd_data_i;
    assign rd_vld_o      = r_rd_vld;
    assign owner_o       = r_owner;
    assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arb.sv
// Directed bench for ram_arb: inputs change just after the rising edge,
// outputs are checked on the falling edge.
module tb_ram_arb;

    localparam int XLEN = 32;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [1:0]           req_i;
    logic [1:0]           we_i;
    logic [1:0][XLEN-1:0] addr_i;
    logic [1:0][XLEN-1:0] wr_data_i;
    logic [1:0][3:0]      byte_en_i;
    logic [1:0]           lock_i;
    logic [1:0]           gnt_o;
    logic [XLEN-1:0]      rd_data_o;
    logic [1:0]           rd_vld_o;
    logic                 mem_en_o;
    logic                 mem_we_o;
    logic [XLEN-1:0]      mem_addr_o;
    logic [XLEN-1:0]      mem_wr_data_o;
    logic [3:0]           mem_byte_en_o;
    logic [XLEN-1:0]      mem_rd_data_i;
    logic                 owner_o;
    logic                 busy_o;

    int checks = 0;
    int errors = 0;

    ram_arb #(.XLEN(XLEN), .MAX_BURST(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .wr_data_i     (wr_data_i),
        .byte_en_i     (byte_en_i),
        .lock_i        (lock_i),
        .gnt_o         (gnt_o),
        .rd_data_o     (rd_data_o),
        .rd_vld_o      (rd_vld_o),
        .mem_en_o      (mem_en_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wr_data_o (mem_wr_data_o),
        .mem_byte_en_o (mem_byte_en_o),
        .mem_rd_data_i (mem_rd_data_i),
        .owner_o       (owner_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic drv(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock);
        req_i  = req;
        we_i   = we;
        lock_i = lock;
    endtask

    initial begin
        rst_i         = 1'b1;
        req_i         = 2'b11;
        we_i          = 2'b00;
        lock_i        = 2'b00;
        addr_i[0]     = 32'h0000_0100;
        addr_i[1]     = 32'h0000_0200;
        wr_data_i[0]  = 32'hA5A5_A5A5;
        wr_data_i[1]  = 32'h5A5A_5A5A;
        byte_en_i[0]  = 4'b0011;
        byte_en_i[1]  = 4'b1111;
        mem_rd_data_i = 32'h1111_1111;

        // reset state, requests ignored while in reset
        nxt(); nxt();
        smp();
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_mem_en", 32'(mem_en_o), 32'h0);
        chk("rst_mem_we", 32'(mem_we_o), 32'h0);
        chk("rst_rd_vld", 32'(rd_vld_o), 32'h0);
        chk("rst_owner", 32'(owner_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);

        // contested reads alternate starting with requester 0
        nxt(); rst_i = 1'b0; drv(2'b11, 2'b00, 2'b00);
        smp();
        chk("rr_gnt_a", 32'(gnt_o), 32'h1);
        chk("rr_addr_a", mem_addr_o, 32'h100);
        chk("rr_en_a", 32'(mem_en_o), 32'h1);
        chk("rr_we_a", 32'(mem_we_o), 32'h0);
        chk("rr_be_a", 32'(mem_byte_en_o), 32'h0);
        nxt(); smp();
        chk("rr_gnt_b", 32'(gnt_o), 32'h2);
        chk("rr_addr_b", mem_addr_o, 32'h200);
        chk("rr_vld_b", 32'(rd_vld_o), 32'h1);
        chk("rr_rdata_b", rd_data_o, 32'h1111_1111);
        chk("rr_owner_b", 32'(owner_o), 32'h0);
        nxt(); smp();
        chk("rr_gnt_c", 32'(gnt_o), 32'h1);
        chk("rr_vld_c", 32'(rd_vld_o), 32'h2);
        chk("rr_owner_c", 32'(owner_o), 32'h1);
        nxt(); drv(2'b00, 2'b00, 2'b00);
        smp();
        chk("idle_gnt", 32'(gnt_o), 32'h0);
        chk("idle_en", 32'(mem_en_o), 32'h0);
        chk("idle_vld", 32'(rd_vld_o), 32'h1);
        nxt(); smp();
        chk("idle_vld2", 32'(rd_vld_o), 32'h0);

        // write by requester 0
        nxt(); drv(2'b01, 2'b01, 2'b00); addr_i[0] = 32'h10;
        smp();
        chk("wr_gnt", 32'(gnt_o), 32'h1);
        chk("wr_we", 32'(mem_we_o), 32'h1);
        chk("wr_be", 32'(mem_byte_en_o), 32'h3);
        chk("wr_addr", mem_addr_o, 32'h10);
        chk("wr_data", mem_wr_data_o, 32'hA5A5_A5A5);
        nxt(); drv(2'b00, 2'b00, 2'b00);
        smp();
        chk("wr_no_vld", 32'(rd_vld_o), 32'h0);

        // read by requester 1 returns RAM data one cycle later
        nxt(); drv(2'b10, 2'b00, 2'b00);
        smp();
        chk("rd1_gnt", 32'(gnt_o), 32'h2);
        nxt(); drv(2'b00, 2'b00, 2'b00); mem_rd_data_i = 32'hDEAD_BEEF;
        smp();
        chk("rd1_vld", 32'(rd_vld_o), 32'h2);
        chk("rd1_data", rd_data_o, 32'hDEAD_BEEF);

        // locked burst by 1 capped at 8 beats while 0 waits
        nxt(); drv(2'b10, 2'b00, 2'b10);
        smp();
        chk("burst_b1_gnt", 32'(gnt_o), 32'h2);
        chk("burst_b1_busy", 32'(busy_o), 32'h0);
        for (int b = 2; b <= 8; b++) begin
            nxt(); drv(2'b11, 2'b00, 2'b10);
            smp();
            chk($sformatf("burst_b%0d_gnt", b), 32'(gnt_o), 32'h2);
            chk($sformatf("burst_b%0d_busy", b), 32'(busy_o), 32'h1);
        end
        nxt(); smp();
        chk("burst_b9_gnt", 32'(gnt_o), 32'h1);
        chk("burst_b9_busy", 32'(busy_o), 32'h0);
        chk("burst_b9_vld", 32'(rd_vld_o), 32'h2);
        nxt(); drv(2'b00, 2'b00, 2'b00);
        nxt();

        // owner 0 abandons a locked burst
        drv(2'b01, 2'b00, 2'b01);
        smp();
        chk("ab_gnt0", 32'(gnt_o), 32'h1);
        nxt(); drv(2'b11, 2'b00, 2'b01);
        smp();
        chk("ab_block", 32'(gnt_o), 32'h1);
        chk("ab_busy", 32'(busy_o), 32'h1);
        nxt(); drv(2'b10, 2'b00, 2'b00);
        smp();
        chk("ab_drop_gnt", 32'(gnt_o), 32'h0);
        chk("ab_drop_en", 32'(mem_en_o), 32'h0);
        nxt(); smp();
        chk("ab_idle_gnt", 32'(gnt_o), 32'h2);
        chk("ab_idle_busy", 32'(busy_o), 32'h0);
        nxt(); drv(2'b00, 2'b00, 2'b00);
        nxt();

        // reset during LOCK1 with a read outstanding
        drv(2'b10, 2'b00, 2'b10);
        nxt(); smp();
        chk("rl_gnt", 32'(gnt_o), 32'h2);
        chk("rl_busy", 32'(busy_o), 32'h1);
        nxt(); rst_i = 1'b1;
        smp();
        chk("rl_rst_gnt", 32'(gnt_o), 32'h0);
        chk("rl_rst_en", 32'(mem_en_o), 32'h0);
        nxt(); smp();
        chk("rl_after_vld", 32'(rd_vld_o), 32'h0);
        chk("rl_after_busy", 32'(busy_o), 32'h0);
        chk("rl_after_gnt", 32'(gnt_o), 32'h0);
        nxt(); rst_i = 1'b0; drv(2'b11, 2'b00, 2'b00);
        smp();
        chk("rl_first_gnt", 32'(gnt_o), 32'h1);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
